// File: rtl/impix_pio_pkg.sv
// Shared constants for the PIO input block: register offsets and edge-type encodings.
package impix_pio_pkg;

    localparam logic [1:0] PIO_OFS_DATA = 2'd0;
    localparam logic [1:0] PIO_OFS_RSVD = 2'd1;
    localparam logic [1:0] PIO_OFS_MASK = 2'd2;
    localparam logic [1:0] PIO_OFS_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/impix_system_pio_in_if.sv
// Avalon-MM slave bus of the PIO input block (word addressed, one-cycle read latency).
interface impix_system_pio_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/impix_pio_in_edge_detect.sv
// Input synchronizer plus per-bit edge pulse generation.
// Edge logic exists only when IMPIX_PIO_IN_EDGE_CAPTURE_EN is defined.
module impix_pio_in_edge_detect
    import impix_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync2
`ifdef IMPIX_PIO_IN_EDGE_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] edge_pulse
`endif
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("impix_pio_in_edge_detect: WIDTH must be 1..32");
    end
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge_type
        $error("impix_pio_in_edge_detect: EDGE_TYPE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] sync1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef IMPIX_PIO_IN_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] raw_edge;
    // settle[2] marks that sync_d holds real pin data, so the reset-to-pin
    // transition through the synchronizer never registers as an edge.
    logic [2:0]       settle;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_d <= '0;
            settle <= '0;
        end else begin
            sync_d <= sync2;
            settle <= {settle[1:0], 1'b1};
        end
    end

    always_comb begin
        raw_edge = '0;
        case (EDGE_TYPE)
            EDGE_FALL: raw_edge = ~sync2 & sync_d;
            EDGE_ANY:  raw_edge = sync2 ^ sync_d;
            default:   raw_edge = sync2 & ~sync_d;
        endcase
        edge_pulse = settle[2] ? raw_edge : '0;
    end
`endif

endmodule

// File: rtl/impix_system_pio_in.sv
// PIO input port with data register and optional edge capture / interrupt.
// Edge capture, interrupt mask and irq are built only with IMPIX_PIO_IN_EDGE_CAPTURE_EN.
module impix_system_pio_in
    import impix_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    impix_system_pio_in_if.slave   bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0] sync2;
    logic [31:0]      read_mux;

    // Bus bits that some builds never decode; folded here to keep them accounted for.
    logic unused_bus;
    assign unused_bus = &{1'b0, bus.chipselect, bus.write_n, bus.writedata};

`ifdef IMPIX_PIO_IN_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] interruptmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;

    impix_pio_in_edge_detect #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_detect (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync2      (sync2),
        .edge_pulse (edge_pulse)
    );

    assign wr_en      = bus.chipselect && !bus.write_n;
    assign clear_bits = (wr_en && bus.address == PIO_OFS_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    // A fresh edge is OR-ed in after the clear so it survives a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            interruptmask <= '0;
            edgecapture   <= '0;
        end else begin
            if (wr_en && bus.address == PIO_OFS_MASK)
                interruptmask <= bus.writedata[WIDTH-1:0];
            edgecapture <= (edgecapture & ~clear_bits) | edge_pulse;
        end
    end

    assign irq = |(edgecapture & interruptmask);

    always_comb begin
        read_mux = '0;
        case (bus.address)
            PIO_OFS_DATA: read_mux[WIDTH-1:0] = sync2;
            PIO_OFS_MASK: read_mux[WIDTH-1:0] = interruptmask;
            PIO_OFS_EDGE: read_mux[WIDTH-1:0] = edgecapture;
            default:      read_mux = '0;
        endcase
    end
`else
    impix_pio_in_edge_detect #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync2   (sync2)
    );

    assign irq = 1'b0;

    always_comb begin
        read_mux = '0;
        if (bus.address == PIO_OFS_DATA)
            read_mux[WIDTH-1:0] = sync2;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= read_mux;
    end

endmodule
